// File: rtl/sram_arb_pkg.sv
// Shared types and default timing for the base-SRAM port arbiter.
package sram_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR_SET,
    S_WR_PULSE,
    S_WR_HOLD
  } state_t;

  typedef enum logic {
    REQ_I,
    REQ_D
  } req_id_t;

  localparam int RD_WAIT_DEF  = 2;
  localparam int WR_PULSE_DEF = 2;

  function automatic int max_wait(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Wait-state down-counter: loads on state entry, decrements to zero and holds there.
module sram_wait_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one asynchronous-SRAM port between instruction fetch and data memory,
// generating read/write strobe timing with wait states and one-cycle fin pulses.
//
// state       | meaning
// S_IDLE      | no access; requests sampled and granted here
// S_RD        | ce/oe low for RD_WAIT cycles, data captured on the last edge
// S_WR_SET    | address/data set up, we_n still high
// S_WR_PULSE  | we_n low for WR_PULSE cycles
// S_WR_HOLD   | we_n high, data still driven; d_wfin follows
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W   = 20,
  parameter int RD_WAIT  = RD_WAIT_DEF,
  parameter int WR_PULSE = WR_PULSE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read_ce,
  input  logic [31:0]       i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_fin,
  input  logic              d_read_ce,
  input  logic              d_write_ce,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_be,
  output logic [31:0]       d_rdata,
  output logic              d_rfin,
  output logic              d_wfin,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_data_oe,
  input  logic [31:0]       ram_rdata,
  output logic [3:0]        ram_be_n,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n,
  output logic              busy
);

  localparam int CW = $clog2(max_wait(RD_WAIT, WR_PULSE)) + 1;

  state_t        state, state_nxt;
  req_id_t       req_id;
  logic          last_d;
  logic [3:0]    be_n_q;
  logic          i_req, d_req;
  logic          grant_i, grant_d;
  logic          cnt_load, cnt_zero;
  logic [CW-1:0] cnt_load_val;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^{i_addr[31:ADDR_W+2], i_addr[1:0], d_addr[31:ADDR_W+2], d_addr[1:0]};

  // A side whose fin is high this cycle is masked so a still-held ce cannot re-grant.
  assign i_req = i_read_ce & ~i_fin;
  assign d_req = (d_read_ce | d_write_ce) & ~(d_rfin | d_wfin);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    grant_i      = 1'b0;
    grant_d      = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    ram_ce_n     = 1'b0;
    ram_oe_n     = 1'b1;
    ram_we_n     = 1'b1;
    ram_data_oe  = 1'b0;
    case (state)
      S_IDLE: begin
        ram_ce_n = 1'b1;
        // d-side has priority unless it went last and i is waiting.
        if (d_req && !(last_d && i_req)) begin
          grant_d      = 1'b1;
          state_nxt    = d_write_ce ? S_WR_SET : S_RD;
          cnt_load     = ~d_write_ce;
          cnt_load_val = CW'(RD_WAIT - 1);
        end else if (i_req) begin
          grant_i      = 1'b1;
          state_nxt    = S_RD;
          cnt_load     = 1'b1;
          cnt_load_val = CW'(RD_WAIT - 1);
        end
      end
      S_RD: begin
        ram_oe_n = 1'b0;
        if (cnt_zero) state_nxt = S_IDLE;
      end
      S_WR_SET: begin
        ram_data_oe  = 1'b1;
        state_nxt    = S_WR_PULSE;
        cnt_load     = 1'b1;
        cnt_load_val = CW'(WR_PULSE - 1);
      end
      S_WR_PULSE: begin
        ram_data_oe = 1'b1;
        ram_we_n    = 1'b0;
        if (cnt_zero) state_nxt = S_WR_HOLD;
      end
      S_WR_HOLD: begin
        ram_data_oe = 1'b1;
        state_nxt   = S_IDLE;
      end
      default: begin
        ram_ce_n  = 1'b1;
        state_nxt = S_IDLE;
      end
    endcase
  end

  sram_wait_counter #(.W(CW)) u_wait (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_fin     <= 1'b0;
      d_rfin    <= 1'b0;
      d_wfin    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      be_n_q    <= 4'hF;
      last_d    <= 1'b0;
      req_id    <= REQ_I;
    end else begin
      i_fin  <= 1'b0;
      d_rfin <= 1'b0;
      d_wfin <= 1'b0;
      if (grant_d) begin
        ram_addr <= d_addr[ADDR_W+1:2];
        be_n_q   <= ~d_be;
        last_d   <= 1'b1;
        req_id   <= REQ_D;
        if (d_write_ce) ram_wdata <= d_wdata;
      end else if (grant_i) begin
        ram_addr <= i_addr[ADDR_W+1:2];
        be_n_q   <= 4'h0;
        last_d   <= 1'b0;
        req_id   <= REQ_I;
      end
      if (state == S_RD && cnt_zero) begin
        if (req_id == REQ_D) begin
          d_rdata <= ram_rdata;
          d_rfin  <= 1'b1;
        end else begin
          i_rdata <= ram_rdata;
          i_fin   <= 1'b1;
        end
      end
      if (state == S_WR_HOLD) d_wfin <= 1'b1;
    end
  end

  assign ram_be_n = (state == S_IDLE) ? 4'hF : be_n_q;
  assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural SRAM model and fin scoreboard.
module tb_sram_port_arbiter;

  localparam logic [2:0] K_I = 3'b100;
  localparam logic [2:0] K_D = 3'b010;
  localparam logic [2:0] K_W = 3'b001;

  typedef struct {
    logic [2:0]  kind;
    logic [31:0] data;
  } exp_t;

  logic        clk, rst;
  logic        i_read_ce, d_read_ce, d_write_ce;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_be;
  logic [31:0] i_rdata, d_rdata, ram_wdata, ram_rdata;
  logic        i_fin, d_rfin, d_wfin;
  logic [19:0] ram_addr;
  logic        ram_data_oe, ram_ce_n, ram_oe_n, ram_we_n, busy;
  logic [3:0]  ram_be_n;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [logic [19:0]];
  exp_t        exp_q[$];
  logic [2:0]  obs_kind [0:63];
  logic [31:0] obs_data [0:63];
  int          fin_n = 0;
  int          rd_n = 0;
  int          oe_cnt = 0, we_cnt = 0, doe_cnt = 0;

  sram_port_arbiter dut (
    .clk(clk), .rst(rst),
    .i_read_ce(i_read_ce), .i_addr(i_addr), .i_rdata(i_rdata), .i_fin(i_fin),
    .d_read_ce(d_read_ce), .d_write_ce(d_write_ce), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_be(d_be), .d_rdata(d_rdata), .d_rfin(d_rfin), .d_wfin(d_wfin),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_data_oe(ram_data_oe),
    .ram_rdata(ram_rdata), .ram_be_n(ram_be_n), .ram_ce_n(ram_ce_n),
    .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] init_val(input logic [19:0] a);
    return 32'h3401_0001 ^ ((({12'h0, a}) ^ 32'd4) << 8);
  endfunction

  function automatic logic [31:0] mem_rd(input logic [19:0] a);
    return mem.exists(a) ? mem[a] : init_val(a);
  endfunction

  // SRAM model: data only valid while selected and output-enabled.
  always @(negedge clk) begin
    ram_rdata = (!ram_ce_n && !ram_oe_n) ? mem_rd(ram_addr) : 32'hxxxx_xxxx;
    if (!ram_ce_n && !ram_we_n && ram_data_oe) begin
      logic [31:0] w;
      w = mem_rd(ram_addr);
      for (int b = 0; b < 4; b++)
        if (!ram_be_n[b]) w[8*b +: 8] = ram_wdata[8*b +: 8];
      mem[ram_addr] = w;
    end
    if (!rst) begin
      oe_cnt  = oe_cnt + int'(!ram_ce_n && !ram_oe_n);
      we_cnt  = we_cnt + int'(!ram_ce_n && !ram_we_n);
      doe_cnt = doe_cnt + int'(ram_data_oe);
    end
    if ((i_fin || d_rfin || d_wfin) && fin_n < 64) begin
      obs_kind[fin_n] = {i_fin, d_rfin, d_wfin};
      obs_data[fin_n] = i_fin ? i_rdata : (d_rfin ? d_rdata : mem_rd(ram_addr));
      fin_n = fin_n + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [2:0] kind, input logic [31:0] data);
    exp_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic sb_check(input string tag);
    exp_t e;
    check({tag, "_fin_seen"}, 32'(fin_n > rd_n), 32'd1);
    if (fin_n > rd_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_kind"}, 32'(obs_kind[rd_n]), 32'(e.kind));
      check({tag, "_data"}, obs_data[rd_n], e.data);
      rd_n++;
    end
  endtask

  task automatic wait_fin(input string tag, input int exp_cyc);
    int cyc;
    bit got;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
      got = i_fin | d_rfin | d_wfin;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
  endtask

  initial begin
    int oe0, we0, doe0;
    logic [31:0] wexp;

    rst = 1'b1;
    i_read_ce = 1'b0; d_read_ce = 1'b0; d_write_ce = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0;
    repeat (2) @(negedge clk);
    check("rst_ce_n", 32'(ram_ce_n), 32'd1);
    check("rst_oe_n", 32'(ram_oe_n), 32'd1);
    check("rst_we_n", 32'(ram_we_n), 32'd1);
    check("rst_be_n", 32'(ram_be_n), 32'hF);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fins", 32'({i_fin, d_rfin, d_wfin}), 32'd0);
    check("rst_addr", 32'(ram_addr), 32'd0);
    check("rst_data_oe", 32'(ram_data_oe), 32'd0);
    rst = 1'b0;

    // 1: i-only read
    @(negedge clk);
    i_read_ce = 1'b1; i_addr = 32'h8000_0010;
    push_exp(K_I, 32'h3401_0001);
    @(posedge clk); #1;
    check("t1_addr", 32'(ram_addr), 32'h4);
    check("t1_oe_n", 32'(ram_oe_n), 32'd0);
    check("t1_be_n", 32'(ram_be_n), 32'h0);
    oe0 = oe_cnt;
    wait_fin("t1", 2);
    i_read_ce = 1'b0;
    check("t1_oe_cycles", 32'(oe_cnt - oe0), 32'd2);
    check("t1_i_rdata", i_rdata, 32'h3401_0001);
    @(negedge clk); #1;
    sb_check("t1");

    // 3: simultaneous i and d reads, d first (misaligned d address)
    @(negedge clk);
    i_read_ce = 1'b1; i_addr = 32'h8000_0020;
    d_read_ce = 1'b1; d_addr = 32'h8000_0033; d_be = 4'hF;
    push_exp(K_D, mem_rd(20'hC));
    push_exp(K_I, mem_rd(20'h8));
    @(posedge clk); #1;
    check("t3_d_addr", 32'(ram_addr), 32'hC);
    check("t3_d_be_n", 32'(ram_be_n), 32'h0);
    wait_fin("t3_d", 2);
    d_read_ce = 1'b0;
    @(negedge clk); #1;
    sb_check("t3_d");
    wait_fin("t3_i", 3);
    i_read_ce = 1'b0;
    @(negedge clk); #1;
    sb_check("t3_i");

    // 2: partial-byte write
    @(negedge clk);
    d_write_ce = 1'b1; d_addr = 32'h8000_0004; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
    wexp = mem_rd(20'h1);
    for (int b = 0; b < 4; b++)
      if (d_be[b]) wexp[8*b +: 8] = d_wdata[8*b +: 8];
    push_exp(K_W, wexp);
    @(posedge clk); #1;
    check("t2_be_n", 32'(ram_be_n), 32'hC);
    check("t2_addr", 32'(ram_addr), 32'h1);
    check("t2_wdata", ram_wdata, 32'hDEAD_BEEF);
    check("t2_set_we_n", 32'(ram_we_n), 32'd1);
    check("t2_set_data_oe", 32'(ram_data_oe), 32'd1);
    we0 = we_cnt; doe0 = doe_cnt;
    wait_fin("t2", 4);
    d_write_ce = 1'b0;
    check("t2_we_cycles", 32'(we_cnt - we0), 32'd2);
    check("t2_doe_cycles", 32'(doe_cnt - doe0), 32'd4);
    @(negedge clk); #1;
    sb_check("t2");

    // 6: request held through its fin cycle yields one transaction
    @(negedge clk);
    i_read_ce = 1'b1; i_addr = 32'h8000_0070;
    push_exp(K_I, mem_rd(20'h1C));
    wait_fin("t6", 3);
    @(posedge clk); #1;
    check("t6_no_regrant", 32'(busy), 32'd0);
    i_read_ce = 1'b0;
    sb_check("t6");
    repeat (4) @(posedge clk);
    #1;
    check("t6_no_extra_fin", 32'(fin_n), 32'(rd_n));

    // 4: continuous d reads with a waiting i alternate D,I,D,I
    @(negedge clk);
    d_read_ce = 1'b1; d_addr = 32'h8000_0040; d_be = 4'hF;
    i_read_ce = 1'b1; i_addr = 32'h8000_0054;
    push_exp(K_D, mem_rd(20'h10));
    push_exp(K_I, mem_rd(20'h15));
    push_exp(K_D, mem_rd(20'h10));
    push_exp(K_I, mem_rd(20'h15));
    wait_fin("t4_0", 3);
    @(negedge clk); #1;
    sb_check("t4_0");
    wait_fin("t4_1", 3);
    @(negedge clk); #1;
    sb_check("t4_1");
    wait_fin("t4_2", 3);
    @(negedge clk); #1;
    sb_check("t4_2");
    wait_fin("t4_3", 3);
    d_read_ce = 1'b0; i_read_ce = 1'b0;
    @(negedge clk); #1;
    sb_check("t4_3");

    // 5: reset during the write pulse
    @(negedge clk);
    d_write_ce = 1'b1; d_addr = 32'h8000_0060; d_wdata = 32'h1234_5678; d_be = 4'hF;
    @(posedge clk); #1;
    check("t5_set_we_n", 32'(ram_we_n), 32'd1);
    @(posedge clk); #1;
    check("t5_pulse_we_n", 32'(ram_we_n), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_we_n", 32'(ram_we_n), 32'd1);
    check("t5_rst_ce_n", 32'(ram_ce_n), 32'd1);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_data_oe", 32'(ram_data_oe), 32'd0);
    check("t5_rst_i_rdata", i_rdata, 32'd0);
    d_write_ce = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("t5_no_wfin", 32'(fin_n), 32'(rd_n));
    check("t5_idle", 32'(busy), 32'd0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
